ifft8_engine: RTL
=================

# ifft8_engine

Sequential 8-point radix-2 inverse FFT engine, the inverse-direction counterpart of the forward FFT datapath. It accepts eight frequency-domain complex samples on a valid/ready stream and computes the time-domain result in place, one butterfly per clock with conjugate Q8 twiddles and 1/2 scaling per stage (1/8 total). It then streams the eight results out in natural order. It sits downstream of the forward FFT path for loopback and reconstruction.

## Interface
- DW, 16, sample component width (signed, two's complement)
- TW, 16, twiddle component width (Q8: 256 = 1.0)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; one clock, asynchronous assertion, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  engine can accept an input sample
- in_r, in_i  in  DW  input sample X[k], real and imaginary, k = 0..7 in arrival order
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output sample
- out_r, out_i  out  DW  output sample x[n], n = 0..7 in emission order
- out_last  out  1  high with n = 7
- busy  out  1  high in COMPUTE and UNLOAD

## Operation
- Three states: LOAD, COMPUTE, UNLOAD. Reset enters LOAD.
- LOAD:
  - in_ready = 1.
  - Each beat with in_valid & in_ready writes mem[bitrev3(cnt)], then cnt increments.
  - Beat 7 moves to COMPUTE with cnt = 0.
- COMPUTE: 12 cycles, one butterfly per cycle. Each butterfly reads mem[p] and mem[q] and writes both back in the same cycle.
  - Stage 0: pairs (0,1)(2,3)(4,5)(6,7), k = 0.
  - Stage 1: pairs (0,2)(1,3)(4,6)(5,7), k = 0,2,0,2.
  - Stage 2: pairs (0,4)(1,5)(2,6)(3,7), k = 0,1,2,3.
  - After the 12th cycle the state moves to UNLOAD with cnt = 0.
- Twiddles W[k] = conj(W8^k) in Q8: k0 = (256,0), k1 = (181,181), k2 = (0,256), k3 = (-181,181).
- Butterfly arithmetic, with a = mem[p], b = mem[q]:
  - t_r = (b_r*w_r >>> 8) - (b_i*w_i >>> 8)
  - t_i = (b_r*w_i >>> 8) + (b_i*w_r >>> 8)
  - Products are 32-bit signed; >>> is arithmetic (floor).
  - y1 = sat_DW((a + t) >>> 1), y2 = sat_DW((a - t) >>> 1). Sums are computed in DW+2 bits.
  - Saturation clamps to [-32768, 32767].
- UNLOAD:
  - out_valid = 1, out_r/out_i = mem[cnt], out_last = (cnt == 7).
  - cnt advances only on out_valid & out_ready. Output must hold stable while out_ready = 0.
  - The beat-7 handshake moves the state to LOAD.
- in_ready = 0 in COMPUTE and UNLOAD. in_valid is ignored there and no data is consumed.

## Timing
- Reset values:
  - in_ready = 1; out_valid, out_last and busy = 0.
  - out_r and out_i = 0.
  - mem entries = 0; cnt = 0.
- Reset mid-operation (any state) aborts the frame immediately: back to LOAD, all values as above. No partial output.
- Latency:
  - The last input beat at cycle T gives COMPUTE in cycles T+1..T+12.
  - out_valid first goes high at T+13.
  - With out_ready held at 1, out_last is at T+20 and in_ready is high again at T+21.
- No overlap: the next frame's first input is accepted no earlier than the cycle after the beat-7 output handshake.
- Outputs are registered (state- and cnt-driven). out_valid never drops without a handshake.

## Structure
- Package ifft8_pkg holds:
  - the state enum (LOAD, COMPUTE, UNLOAD);
  - DW and TW defaults;
  - the twiddle constant array W_R/W_I[0..3];
  - the 12-entry schedule constants P, Q, K;
  - the bitrev3 function.
- Sub-module ifft8_bf: combinational butterfly (a, b, w -> y1, y2) with the scaling and saturation above. It is instantiated once in the engine.
- The engine holds the 8×2×DW register array, the FSM and the 4-bit cycle counter.

## Test plan
- DC frame: X[k] = (800,0) for all k -> x[0] = (800,0), x[1..7] = (0,0). out_last is on beat 7.
- Impulse: X[0] = (800,0), others 0 -> all x[n] = (100,0).
- Single tone: X[1] = (2048,0), others 0 -> x[n] ≈ 256·e^{j2πn/8} within ±2 LSB:
  - x[0] = (256,0), x[2] = (0,256), x[4] = (-256,0);
  - x[1] ≈ (181,181).
- ifft8_bf saturation: a = (32767,32767), b = (32767,32767), w = (181,181) -> y1 = (16383,32767), y2 = (16383,-6784).
- Backpressure: out_ready toggles 1,0,0,1 repeatedly -> output values are held while stalled, the sequence matches the DC case, and in_ready stays 0 until the final handshake. Input offered during COMPUTE is not consumed.
- Reset at COMPUTE cycle 6 -> next cycle shows LOAD, in_ready = 1, out_valid = 0. A fresh DC frame afterwards yields correct output.

Source files
------------

// File: rtl/ifft8_pkg.sv
// Shared types, constants and helpers for the 8-point inverse FFT engine.
package ifft8_pkg;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam int NBF = 12;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  // Conjugated radix-8 twiddles in Q8 (256 = 1.0), indexed by k.
  localparam logic signed [TW-1:0] W_R [4] = '{16'sd256, 16'sd181, 16'sd0, -16'sd181};
  localparam logic signed [TW-1:0] W_I [4] = '{16'sd0, 16'sd181, 16'sd256, 16'sd181};

  // In-place butterfly schedule: three stages of four butterflies each.
  localparam logic [2:0] SCHED_P [NBF] = '{3'd0, 3'd2, 3'd4, 3'd6,
                                           3'd0, 3'd1, 3'd4, 3'd5,
                                           3'd0, 3'd1, 3'd2, 3'd3};
  localparam logic [2:0] SCHED_Q [NBF] = '{3'd1, 3'd3, 3'd5, 3'd7,
                                           3'd2, 3'd3, 3'd6, 3'd7,
                                           3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [1:0] SCHED_K [NBF] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                           2'd0, 2'd2, 2'd0, 2'd2,
                                           2'd0, 2'd1, 2'd2, 2'd3};

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // Clamp a DW+2 bit intermediate to the signed DW range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+1:0] v);
    logic signed [DW-1:0] res;
    if (v > 18'sd32767) begin
      res = 16'sh7FFF;
    end else if (v < -18'sd32768) begin
      res = 16'sh8000;
    end else begin
      res = v[DW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ifft8_if.sv
// Sample stream bundle: frequency-domain input and time-domain output.
interface ifft8_if;
  import ifft8_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  logic                 out_last;
  logic                 busy;

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_last, busy
  );

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_last, busy
  );

endinterface

// File: rtl/ifft8_bf.sv
// Combinational radix-2 butterfly with twiddle multiply, 1/2 scaling and saturation.
module ifft8_bf
  import ifft8_pkg::*;
(
  input  logic signed [DW-1:0] a_r,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_r,
  input  logic signed [DW-1:0] b_i,
  input  logic signed [TW-1:0] w_r,
  input  logic signed [TW-1:0] w_i,
  output logic signed [DW-1:0] y1_r,
  output logic signed [DW-1:0] y1_i,
  output logic signed [DW-1:0] y2_r,
  output logic signed [DW-1:0] y2_i
);

  localparam int SW = DW + 2;

  logic signed [31:0]   p_rr, p_ii, p_ri, p_ir;
  logic signed [31:0]   q_rr, q_ii, q_ri, q_ir;
  logic signed [SW-1:0] t_r, t_i, a_xr, a_xi;
  logic signed [SW-1:0] s1_r, s1_i, s2_r, s2_i;

  // Twiddle product b*w, each partial product floored by 8 before combining.
  always_comb begin
    p_rr = $signed({{(32-DW){b_r[DW-1]}}, b_r}) * $signed({{(32-TW){w_r[TW-1]}}, w_r});
    p_ii = $signed({{(32-DW){b_i[DW-1]}}, b_i}) * $signed({{(32-TW){w_i[TW-1]}}, w_i});
    p_ri = $signed({{(32-DW){b_r[DW-1]}}, b_r}) * $signed({{(32-TW){w_i[TW-1]}}, w_i});
    p_ir = $signed({{(32-DW){b_i[DW-1]}}, b_i}) * $signed({{(32-TW){w_r[TW-1]}}, w_r});
    q_rr = p_rr >>> 8;
    q_ii = p_ii >>> 8;
    q_ri = p_ri >>> 8;
    q_ir = p_ir >>> 8;
    t_r  = q_rr[SW-1:0] - q_ii[SW-1:0];
    t_i  = q_ri[SW-1:0] + q_ir[SW-1:0];
  end

  // Sum/difference in DW+2 bits, halve with floor, then clamp.
  always_comb begin
    a_xr = {{2{a_r[DW-1]}}, a_r};
    a_xi = {{2{a_i[DW-1]}}, a_i};
    s1_r = (a_xr + t_r) >>> 1;
    s1_i = (a_xi + t_i) >>> 1;
    s2_r = (a_xr - t_r) >>> 1;
    s2_i = (a_xi - t_i) >>> 1;
    y1_r = sat_dw(s1_r);
    y1_i = sat_dw(s1_i);
    y2_r = sat_dw(s2_r);
    y2_i = sat_dw(s2_i);
  end

endmodule

// File: rtl/ifft8_engine.sv
// Sequential 8-point inverse FFT: load in bit-reversed order, 12 in-place
// butterflies, then stream results out in natural order.
module ifft8_engine
  import ifft8_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  ifft8_if.slave bus
);

  state_t               state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic                 load_en, bf_en;
  logic signed [DW-1:0] mem_re [8];
  logic signed [DW-1:0] mem_im [8];

  logic [2:0]           bf_p, bf_q;
  logic [1:0]           bf_k;
  logic signed [DW-1:0] y1_r, y1_i, y2_r, y2_i;

  assign bf_p = SCHED_P[cnt];
  assign bf_q = SCHED_Q[cnt];
  assign bf_k = SCHED_K[cnt];

  ifft8_bf u_bf (
    .a_r  (mem_re[bf_p]),
    .a_i  (mem_im[bf_p]),
    .b_r  (mem_re[bf_q]),
    .b_i  (mem_im[bf_q]),
    .w_r  (W_R[bf_k]),
    .w_i  (W_I[bf_k]),
    .y1_r (y1_r),
    .y1_i (y1_i),
    .y2_r (y2_r),
    .y2_i (y2_i)
  );

  // Next-state, counter and datapath-enable decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_en    = 1'b0;
    bf_en      = 1'b0;
    case (state)
      LOAD: begin
        if (bus.in_valid) begin
          load_en = 1'b1;
          if (cnt == 4'd7) begin
            state_next = COMPUTE;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end else begin
          cnt_next = cnt;
        end
      end
      COMPUTE: begin
        bf_en = 1'b1;
        if (cnt == 4'd11) begin
          state_next = UNLOAD;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      UNLOAD: begin
        if (bus.out_ready) begin
          if (cnt == 4'd7) begin
            state_next = LOAD;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end else begin
          cnt_next = cnt;
        end
      end
      default: begin
        state_next = LOAD;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State and cycle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Sample memory: bit-reversed loads, then in-place butterfly write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem_re[i] <= 16'sd0;
        mem_im[i] <= 16'sd0;
      end
    end else if (load_en) begin
      mem_re[bitrev3(cnt[2:0])] <= bus.in_r;
      mem_im[bitrev3(cnt[2:0])] <= bus.in_i;
    end else if (bf_en) begin
      mem_re[bf_p] <= y1_r;
      mem_im[bf_p] <= y1_i;
      mem_re[bf_q] <= y2_r;
      mem_im[bf_q] <= y2_i;
    end
  end

  // Registered stream outputs, derived from the upcoming state and count so
  // they line up with the state register; mem[0] is final well before UNLOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.out_r     <= 16'sd0;
      bus.out_i     <= 16'sd0;
    end else begin
      bus.in_ready  <= (state_next == LOAD);
      bus.out_valid <= (state_next == UNLOAD);
      bus.out_last  <= (state_next == UNLOAD) && (cnt_next == 4'd7);
      bus.busy      <= (state_next != LOAD);
      if (state_next == UNLOAD) begin
        bus.out_r <= mem_re[cnt_next[2:0]];
        bus.out_i <= mem_im[cnt_next[2:0]];
      end else begin
        bus.out_r <= bus.out_r;
        bus.out_i <= bus.out_i;
      end
    end
  end

endmodule
